spi_flash_responder: RTL and testbench

SPI-flash responder (slave) that answers the SoC's flash master over the `o_flash_cs_n` / `o_flash_sclk` / `o_flash_mosi` / `i_flash_miso` pins. It is used as a flash stand-in for simulation and FPGA loop-back bring-up. It oversamples the SPI pins on the system clock, decodes READ (0x03), JEDEC ID (0x9F) and READ STATUS (0x05), and serves READ data from an external synchronous memory port. It sits outside `rv32i_soc`, wired to the flash pins in place of the physical device.

---
 rtl/spi_flash_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module : spi_flash_responder
// Desc   : SPI-flash stand-in (mode 0); answers READ, JEDEC ID and READ STATUS.
// Rev    : 1.0  initial release
// ============================================================================
module spi_flash_responder #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4017
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_flash_sclk,
    input  logic                  i_flash_cs_n,
    input  logic                  i_flash_mosi,
    output logic                  o_flash_miso,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  busy
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_cmd    = 3'd1;
    localparam logic [2:0] c_st_addr   = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_id     = 3'd4;
    localparam logic [2:0] c_st_stat   = 3'd5;
    localparam logic [2:0] c_st_ignore = 3'd6;

    localparam logic [7:0] c_cmd_read   = 8'h03;
    localparam logic [7:0] c_cmd_jedec  = 8'h9F;
    localparam logic [7:0] c_cmd_status = 8'h05;

    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    // pipe[0]/[1] form the synchronizer, pipe[2] is the edge-detect delay
    logic [2:0]            r_sclk_pipe;
    logic [2:0]            r_cs_pipe;
    logic [1:0]            r_mosi_pipe;
    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_cs_rise;
    logic                  w_cs_fall;
    logic                  w_mosi;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic                  w_tx_active;
    logic                  w_busy;

    logic [2:0]            r_bit_cnt;
    logic [1:0]            r_byte_cnt;
    logic [6:0]            r_rx_shift;
    logic [7:0]            w_rx_byte;
    logic [ADDR_WIDTH-2:0] r_addr_shift;
    logic [ADDR_WIDTH-1:0] w_addr_full;
    logic                  w_cmd_done;
    logic                  w_addr_done;

    logic [7:0]            r_tx_shift;
    logic [7:0]            r_prefetch;
    logic [2:0]            r_tx_cnt;
    logic                  r_tx_hold;
    logic [1:0]            r_id_idx;
    logic [7:0]            w_id_byte;
    logic                  r_first_rd;
    logic                  r_rdata_vld;
    logic                  r_mem_rd_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;

    // cs_n chain resets low so a select already asserted at reset release is not seen as a fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_pipe <= 3'b000;
            r_cs_pipe   <= 3'b000;
            r_mosi_pipe <= 2'b00;
        end else begin
            r_sclk_pipe <= {r_sclk_pipe[1:0], i_flash_sclk};
            r_cs_pipe   <= {r_cs_pipe[1:0], i_flash_cs_n};
            r_mosi_pipe <= {r_mosi_pipe[0], i_flash_mosi};
        end
    end

    assign w_sclk_rise = r_sclk_pipe[1] & ~r_sclk_pipe[2];
    assign w_sclk_fall = ~r_sclk_pipe[1] & r_sclk_pipe[2];
    assign w_cs_rise   = r_cs_pipe[1] & ~r_cs_pipe[2];
    assign w_cs_fall   = ~r_cs_pipe[1] & r_cs_pipe[2];
    assign w_mosi      = r_mosi_pipe[1];

    assign w_rx_byte   = {r_rx_shift, w_mosi};
    assign w_addr_full = {r_addr_shift, w_mosi};
    assign w_cmd_done  = w_sclk_rise && (r_state == c_st_cmd) && (r_bit_cnt == 3'd7);
    assign w_addr_done = w_sclk_rise && (r_state == c_st_addr) && (r_bit_cnt == 3'd7)
                         && (r_byte_cnt == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_rise) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_cs_fall) w_state_nxt = c_st_cmd;
                end
                c_st_cmd: begin
                    if (w_cmd_done) begin
                        case (w_rx_byte)
                            c_cmd_read:   w_state_nxt = c_st_addr;
                            c_cmd_jedec:  w_state_nxt = c_st_id;
                            c_cmd_status: w_state_nxt = c_st_stat;
                            default:      w_state_nxt = c_st_ignore;
                        endcase
                    end
                end
                c_st_addr: begin
                    if (w_addr_done) w_state_nxt = c_st_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_tx_active = 1'b0;
        w_busy      = (r_state != c_st_idle);
        case (r_state)
            c_st_data, c_st_id, c_st_stat: w_tx_active = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (r_id_idx)
            2'd0:    w_id_byte = JEDEC_ID[23:16];
            2'd1:    w_id_byte = JEDEC_ID[15:8];
            default: w_id_byte = JEDEC_ID[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt    <= 3'd0;
            r_byte_cnt   <= 2'd0;
            r_rx_shift   <= 7'd0;
            r_addr_shift <= '0;
            r_tx_shift   <= 8'd0;
            r_prefetch   <= 8'd0;
            r_tx_cnt     <= 3'd0;
            r_tx_hold    <= 1'b0;
            r_id_idx     <= 2'd0;
            r_first_rd   <= 1'b0;
            r_rdata_vld  <= 1'b0;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= '0;
        end else if (w_cs_rise) begin
            r_bit_cnt    <= 3'd0;
            r_byte_cnt   <= 2'd0;
            r_rx_shift   <= 7'd0;
            r_addr_shift <= '0;
            r_tx_shift   <= 8'd0;
            r_prefetch   <= 8'd0;
            r_tx_cnt     <= 3'd0;
            r_tx_hold    <= 1'b0;
            r_id_idx     <= 2'd0;
            r_first_rd   <= 1'b0;
            r_rdata_vld  <= 1'b0;
            r_mem_rd_en  <= 1'b0;
        end else begin
            r_mem_rd_en <= 1'b0;
            r_rdata_vld <= r_mem_rd_en;

            if ((r_state == c_st_idle) && w_cs_fall) begin
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 2'd0;
            end

            if (w_sclk_rise && ((r_state == c_st_cmd) || (r_state == c_st_addr))) begin
                r_bit_cnt    <= r_bit_cnt + 3'd1;
                r_rx_shift   <= w_rx_byte[6:0];
                r_addr_shift <= w_addr_full[ADDR_WIDTH-2:0];
                if (r_bit_cnt == 3'd7) r_byte_cnt <= r_byte_cnt + 2'd1;
            end

            // The byte loaded here is already on MISO before the next fall, so that fall must not shift
            if (w_cmd_done) begin
                r_tx_cnt  <= 3'd0;
                r_tx_hold <= 1'b1;
                if (w_rx_byte == c_cmd_jedec) begin
                    r_tx_shift <= JEDEC_ID[23:16];
                    r_id_idx   <= 2'd1;
                end else begin
                    r_tx_shift <= 8'h00;
                end
            end

            if (w_addr_done) begin
                r_mem_rd_en <= 1'b1;
                r_mem_addr  <= w_addr_full;
                r_first_rd  <= 1'b1;
            end

            if (r_rdata_vld) begin
                if (r_first_rd) begin
                    r_tx_shift  <= mem_rdata;
                    r_first_rd  <= 1'b0;
                    r_tx_cnt    <= 3'd0;
                    r_tx_hold   <= 1'b1;
                    r_mem_rd_en <= 1'b1;
                    r_mem_addr  <= r_mem_addr + c_addr_one;
                end else begin
                    r_prefetch <= mem_rdata;
                end
            end

            if (w_sclk_fall && w_tx_active) begin
                if (r_tx_hold) begin
                    r_tx_hold <= 1'b0;
                end else if (r_tx_cnt == 3'd7) begin
                    r_tx_cnt <= 3'd0;
                    case (r_state)
                        c_st_data: begin
                            r_tx_shift  <= r_prefetch;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= r_mem_addr + c_addr_one;
                        end
                        c_st_id: begin
                            r_tx_shift <= w_id_byte;
                            r_id_idx   <= (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
                        end
                        default: r_tx_shift <= 8'h00;
                    endcase
                end else begin
                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    r_tx_cnt   <= r_tx_cnt + 3'd1;
                end
            end
        end
    end

    assign o_flash_miso = w_tx_active & r_tx_shift[7];
    assign mem_rd_en    = r_mem_rd_en;
    assign mem_addr     = r_mem_addr;
    assign busy         = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_flash_responder
// Desc   : Scoreboard bench for spi_flash_responder (MISO bytes and read addresses).
// Rev    : 1.0  initial release
// ============================================================================
module tb_spi_flash_responder;

    localparam int c_half = 6;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        sclk  = 1'b0;
    logic        cs_n  = 1'b1;
    logic        mosi  = 1'b0;
    logic        miso;
    logic        rd_en;
    logic [15:0] addr;
    logic [7:0]  rdata = 8'h00;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_miso_q [$];
    logic [15:0] exp_addr_q [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    spi_flash_responder #(
        .ADDR_WIDTH (16),
        .JEDEC_ID   (24'hEF4017)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_flash_sclk (sclk),
        .i_flash_cs_n (cs_n),
        .i_flash_mosi (mosi),
        .o_flash_miso (miso),
        .mem_rd_en    (rd_en),
        .mem_addr     (addr),
        .mem_rdata    (rdata),
        .busy         (busy)
    );

    // synchronous backing memory: data one clk after the strobe
    always @(posedge clk) if (rd_en) rdata <= mem[addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // collects MISO bytes at SCLK rises and compares against the expected queue
    initial begin : miso_mon
        logic [7:0] sh;
        int         nb;
        sh = 8'h00;
        nb = 0;
        forever begin
            @(posedge sclk or posedge cs_n or posedge reset);
            if (cs_n || reset) begin
                nb = 0;
            end else begin
                sh = {sh[6:0], miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_miso_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL miso_unexpected: got byte %0h, expected none", sh);
                    end else begin
                        check("miso_byte", 32'(sh), 32'(exp_miso_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : addr_mon
        forever begin
            @(negedge clk);
            if (rd_en === 1'b1) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_rd_unexpected: got addr %0h, expected no read", addr);
                end else begin
                    check("mem_addr", 32'(addr), 32'(exp_addr_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    task automatic start_frame();
        sclk = 1'b0;
        cs_n = 1'b0;
        repeat (c_half) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sclk = 1'b0;
            mosi = data[i];
            repeat (c_half) @(negedge clk);
            sclk = 1'b1;
            repeat (c_half) @(negedge clk);
        end
        check("busy_in_frame", 32'(busy), 32'd1);
    endtask

    // the final SCLK fall coincides with the cs_n rise
    task automatic end_frame();
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("busy_after_cs_rise", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) exp_miso_q.push_back(8'h00);
    endtask

    task automatic read_frame(input logic [23:0] a, input int nbytes);
        start_frame();
        send_bits(32'h03, 8);
        send_bits(32'(a), 24);
        for (int i = 0; i < nbytes; i++) send_bits(32'h0, 8);
        end_frame();
    endtask

    initial begin : stim
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 1);
        mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h3C;
        mem[16'h0012] = 8'h7E;
        mem[16'hFFFF] = 8'hC3;
        mem[16'h0000] = 8'h96;

        repeat (4) @(negedge clk);
        check("reset_miso",  32'(miso),  32'd0);
        check("reset_rd_en", 32'(rd_en), 32'd0);
        check("reset_addr",  32'(addr),  32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // JEDEC ID, wrapping back to the first byte
        push_zeros(1);
        exp_miso_q.push_back(8'hEF);
        exp_miso_q.push_back(8'h40);
        exp_miso_q.push_back(8'h17);
        exp_miso_q.push_back(8'hEF);
        start_frame();
        send_bits(32'h9F, 8);
        for (int i = 0; i < 4; i++) send_bits(32'h0, 8);
        end_frame();

        // READ at 0x000010, three bytes
        push_zeros(4);
        exp_miso_q.push_back(8'hA5);
        exp_miso_q.push_back(8'h3C);
        exp_miso_q.push_back(8'h7E);
        exp_addr_q.push_back(16'h0010);
        exp_addr_q.push_back(16'h0011);
        exp_addr_q.push_back(16'h0012);
        exp_addr_q.push_back(16'h0013);
        read_frame(24'h000010, 3);

        // address wrap at the top of the 16-bit space
        push_zeros(4);
        exp_miso_q.push_back(8'hC3);
        exp_miso_q.push_back(8'h96);
        exp_addr_q.push_back(16'hFFFF);
        exp_addr_q.push_back(16'h0000);
        exp_addr_q.push_back(16'h0001);
        read_frame(24'hFFFFFF, 2);

        // unknown command: MISO stays 0, no reads
        push_zeros(3);
        start_frame();
        send_bits(32'h5A, 8);
        send_bits(32'hFFFF, 16);
        end_frame();

        // READ STATUS
        push_zeros(3);
        start_frame();
        send_bits(32'h05, 8);
        send_bits(32'h0, 16);
        end_frame();

        // abort after 12 address bits, then a clean READ
        push_zeros(2);
        start_frame();
        send_bits(32'h03, 8);
        send_bits(32'hFFF, 12);
        end_frame();
        push_zeros(4);
        exp_miso_q.push_back(8'hA5);
        exp_addr_q.push_back(16'h0010);
        exp_addr_q.push_back(16'h0011);
        read_frame(24'h000010, 1);

        // reset during the third data bit
        push_zeros(4);
        exp_addr_q.push_back(16'h0010);
        exp_addr_q.push_back(16'h0011);
        start_frame();
        send_bits(32'h03, 8);
        send_bits(32'h000010, 24);
        send_bits(32'h0, 2);
        sclk = 1'b0;
        repeat (c_half) @(negedge clk);
        sclk = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_miso",  32'(miso),  32'd0);
        check("rst_mid_busy",  32'(busy),  32'd0);
        check("rst_mid_rd_en", 32'(rd_en), 32'd0);
        @(negedge clk);
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("cs_low_at_release_busy", 32'(busy), 32'd0);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);

        push_zeros(4);
        exp_miso_q.push_back(8'hA5);
        exp_miso_q.push_back(8'h3C);
        exp_miso_q.push_back(8'h7E);
        exp_addr_q.push_back(16'h0010);
        exp_addr_q.push_back(16'h0011);
        exp_addr_q.push_back(16'h0012);
        exp_addr_q.push_back(16'h0013);
        read_frame(24'h000010, 3);

        for (int i = 0; i < 100 && (exp_miso_q.size() != 0 || exp_addr_q.size() != 0); i++)
            @(negedge clk);
        checks++;
        if (exp_miso_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: miso_left=%0d addr_left=%0d, expected 0 and 0",
                     exp_miso_q.size(), exp_addr_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
